// File: rtl/dmem_pkg.sv
// Shared types and constants for the dmem responder: FSM states, word geometry
// and the byte-enable shapes accepted when alignment checking is enabled.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    localparam int WORD_BYTES = 4;

    localparam logic [WORD_BYTES-1:0] BE_NONE    = 4'b0000;
    localparam logic [WORD_BYTES-1:0] BE_BYTE0   = 4'b0001;
    localparam logic [WORD_BYTES-1:0] BE_BYTE1   = 4'b0010;
    localparam logic [WORD_BYTES-1:0] BE_BYTE2   = 4'b0100;
    localparam logic [WORD_BYTES-1:0] BE_BYTE3   = 4'b1000;
    localparam logic [WORD_BYTES-1:0] BE_HALF_LO = 4'b0011;
    localparam logic [WORD_BYTES-1:0] BE_HALF_HI = 4'b1100;
    localparam logic [WORD_BYTES-1:0] BE_WORD    = 4'b1111;

    function automatic logic beIsLegal(input logic [WORD_BYTES-1:0] be);
        logic legal;
        case (be)
            BE_NONE, BE_BYTE0, BE_BYTE1, BE_BYTE2, BE_BYTE3,
            BE_HALF_LO, BE_HALF_HI, BE_WORD: legal = 1'b1;
            default:                         legal = 1'b0;
        endcase
        return legal;
    endfunction

    function automatic logic [8*WORD_BYTES-1:0] beToMask(input logic [WORD_BYTES-1:0] be);
        logic [8*WORD_BYTES-1:0] mask;
        for (int b = 0; b < WORD_BYTES; b++) begin
            mask[8*b +: 8] = {8{be[b]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response bus between a load/store unit (master) and the dmem responder (slave).
interface dmem_if
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid_in;
    logic                  req_ready_out;
    logic [ADDR_WIDTH-1:0] addr_in;
    logic                  WE_in;
    logic [WORD_BYTES-1:0] be_in;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  resp_valid_out;
    logic                  resp_ready_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  err_out;

    modport master (
        output req_valid_in, addr_in, WE_in, be_in, data_in, resp_ready_in,
        input  req_ready_out, resp_valid_out, data_out, err_out
    );

    modport slave (
        input  req_valid_in, addr_in, WE_in, be_in, data_in, resp_ready_in,
        output req_ready_out, resp_valid_out, data_out, err_out
    );
endinterface

// File: rtl/dmem_byte_ram.sv
// Word RAM with combinational read and synchronous per-byte-lane write.
module dmem_byte_ram
    import dmem_pkg::*;
#(
    parameter int IDX_WIDTH = 10
) (
    input  logic                    clk,
    input  logic [IDX_WIDTH-1:0]    idx_i,
    input  logic                    wr_en_i,
    input  logic [WORD_BYTES-1:0]   wr_be_i,
    input  logic [8*WORD_BYTES-1:0] wr_data_i,
    output logic [8*WORD_BYTES-1:0] rd_data_o
);
    localparam int DEPTH = 2 ** IDX_WIDTH;

    logic [WORD_BYTES-1:0][7:0] mem_q [DEPTH];

    // No reset: contents must survive a reset of the responder.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            for (int b = 0; b < WORD_BYTES; b++) begin
                if (wr_be_i[b]) begin
                    mem_q[idx_i][b] <= wr_data_i[8*b +: 8];
                end
            end
        end
    end

    assign rd_data_o = mem_q[idx_i];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one request, waits WAIT_CYCLES, then holds a response.
// Define DMEM_ALIGN_CHECK_EN to flag byte-enable patterns that are not byte/half/word shaped.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDRESS_SPACE = 4096,
    parameter int DATA_WIDTH    = 32,
    parameter int WAIT_CYCLES   = 1
) (
    input  logic  clk,
    input  logic  reset_n,
    dmem_if.slave bus
);
    localparam int AW = $clog2(ADDRESS_SPACE);
    localparam int IW = AW - 2;
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    dmem_state_e           state_q, state_d;
    logic [3:0]            waitCnt_q, waitCnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  we_q, we_d;
    logic [WORD_BYTES-1:0] be_q, be_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic                  accept;
    logic                  enterResp;
    logic [IW-1:0]         opIdx;
    logic                  opWe;
    logic [WORD_BYTES-1:0] opBe;
    logic [DATA_WIDTH-1:0] opWdata;
    logic                  opBeOk;
    logic                  ramWrEn;
    logic [DATA_WIDTH-1:0] ramRdata;
    logic                  unusedAddrLsbs;

    assign unusedAddrLsbs = ^bus.addr_in[1:0];

    assign accept = (state_q == IDLE) && bus.req_valid_in;

    // With zero wait states the commit happens on the accept edge, so take the live bus.
    assign opIdx   = (state_q == IDLE) ? bus.addr_in[AW-1:2] : idx_q;
    assign opWe    = (state_q == IDLE) ? bus.WE_in           : we_q;
    assign opBe    = (state_q == IDLE) ? bus.be_in           : be_q;
    assign opWdata = (state_q == IDLE) ? bus.data_in         : wdata_q;

`ifdef DMEM_ALIGN_CHECK_EN
    assign opBeOk = beIsLegal(opBe);
`else
    assign opBeOk = 1'b1;
`endif

    assign ramWrEn = enterResp && opWe && opBeOk && reset_n;

    dmem_byte_ram #(
        .IDX_WIDTH (IW)
    ) u_ram (
        .clk       (clk),
        .idx_i     (opIdx),
        .wr_en_i   (ramWrEn),
        .wr_be_i   (opBe),
        .wr_data_i (opWdata),
        .rd_data_o (ramRdata)
    );

    always_comb begin
        state_d   = state_q;
        waitCnt_d = waitCnt_q;
        idx_d     = idx_q;
        we_d      = we_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        enterResp = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    idx_d   = bus.addr_in[AW-1:2];
                    we_d    = bus.WE_in;
                    be_d    = bus.be_in;
                    wdata_d = bus.data_in;
                    if (WAIT_CYCLES == 0) begin
                        state_d   = RESP;
                        enterResp = 1'b1;
                    end else begin
                        state_d   = WAIT;
                        waitCnt_d = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (waitCnt_q == 4'd0) begin
                    state_d   = RESP;
                    enterResp = 1'b1;
                end else begin
                    waitCnt_d = waitCnt_q - 4'd1;
                end
            end
            RESP: begin
                if (bus.resp_ready_in) begin
                    state_d = IDLE;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Response payload is captured once and then held until the handshake.
        if (enterResp) begin
            err_d   = !opBeOk;
            rdata_d = (opWe || !opBeOk) ? '0 : (ramRdata & beToMask(opBe));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            waitCnt_q <= 4'd0;
            idx_q     <= '0;
            we_q      <= 1'b0;
            be_q      <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            waitCnt_q <= waitCnt_d;
            idx_q     <= idx_d;
            we_q      <= we_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    assign bus.req_ready_out  = (state_q == IDLE);
    assign bus.resp_valid_out = (state_q == RESP);
    assign bus.data_out       = rdata_q;
    assign bus.err_out        = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with one wait state, one with none.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int WAIT_A = 1;
`ifdef DMEM_ALIGN_CHECK_EN
    localparam logic ALIGN_CHECK = 1'b1;
`else
    localparam logic ALIGN_CHECK = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n;
    int   checkCount = 0;
    int   errorCount = 0;

    dmem_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) busA ();
    dmem_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) busB ();

    dmem_responder #(
        .ADDRESS_SPACE (4096),
        .DATA_WIDTH    (32),
        .WAIT_CYCLES   (WAIT_A)
    ) dutA (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (busA.slave)
    );

    dmem_responder #(
        .ADDRESS_SPACE (4096),
        .DATA_WIDTH    (32),
        .WAIT_CYCLES   (0)
    ) dutB (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (busB.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            errorCount++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // One full transaction on busA; entered and left just after a falling edge.
    task automatic applyStimulus(input string tag, input logic we, input logic [11:0] addr,
                                 input logic [3:0] be, input logic [31:0] wdata,
                                 output logic [31:0] rdata, output logic err, output int lat);
        checkOutput({tag, ".reqReady"}, 32'(busA.req_ready_out), 32'd1);
        busA.req_valid_in = 1'b1;
        busA.WE_in        = we;
        busA.addr_in      = addr;
        busA.be_in        = be;
        busA.data_in      = wdata;
        @(posedge clk);
        #1;
        busA.req_valid_in = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!busA.resp_valid_out && lat < 20);
        rdata = busA.data_out;
        err   = busA.err_out;
        busA.resp_ready_in = 1'b1;
        @(posedge clk);
        #1;
        busA.resp_ready_in = 1'b0;
        @(negedge clk);
    endtask

    task automatic doStore(input string tag, input logic [11:0] addr, input logic [3:0] be,
                           input logic [31:0] wdata, input logic expErr);
        logic [31:0] r;
        logic        e;
        int          l;
        applyStimulus(tag, 1'b1, addr, be, wdata, r, e, l);
        checkOutput({tag, ".latency"}, 32'(l), 32'(WAIT_A + 1));
        checkOutput({tag, ".err"}, 32'(e), 32'(expErr));
        checkOutput({tag, ".data"}, r, 32'h0);
    endtask

    task automatic doLoad(input string tag, input logic [11:0] addr, input logic [3:0] be,
                          input logic [31:0] expData, input logic expErr);
        logic [31:0] r;
        logic        e;
        int          l;
        applyStimulus(tag, 1'b0, addr, be, 32'h0, r, e, l);
        checkOutput({tag, ".latency"}, 32'(l), 32'(WAIT_A + 1));
        checkOutput({tag, ".err"}, 32'(e), 32'(expErr));
        checkOutput({tag, ".data"}, r, expData);
    endtask

    initial begin
        reset_n = 1'b0;
        busA.req_valid_in = 1'b0; busA.WE_in = 1'b0; busA.addr_in = '0;
        busA.be_in = '0; busA.data_in = '0; busA.resp_ready_in = 1'b0;
        busB.req_valid_in = 1'b0; busB.WE_in = 1'b0; busB.addr_in = '0;
        busB.be_in = '0; busB.data_in = '0; busB.resp_ready_in = 1'b0;

        // Reset state
        @(negedge clk);
        checkOutput("rst.respValid", 32'(busA.resp_valid_out), 32'd0);
        checkOutput("rst.data", busA.data_out, 32'h0);
        checkOutput("rst.err", 32'(busA.err_out), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("rst.reqReady", 32'(busA.req_ready_out), 32'd1);
        checkOutput("rstB.reqReady", 32'(busB.req_ready_out), 32'd1);

        // Zero wait states: store then two loads with valid and ready held high
        busB.req_valid_in = 1'b1; busB.resp_ready_in = 1'b1;
        busB.WE_in = 1'b1; busB.addr_in = 12'h040; busB.be_in = 4'b1111; busB.data_in = 32'h5A5A0001;
        @(posedge clk); #1;
        busB.WE_in = 1'b0; busB.be_in = 4'b1111; busB.data_in = 32'h0;
        @(negedge clk);
        checkOutput("w0.st.respValid", 32'(busB.resp_valid_out), 32'd1);
        checkOutput("w0.st.reqReady", 32'(busB.req_ready_out), 32'd0);
        checkOutput("w0.st.data", busB.data_out, 32'h0);
        @(negedge clk);
        checkOutput("w0.gap1.respValid", 32'(busB.resp_valid_out), 32'd0);
        checkOutput("w0.gap1.reqReady", 32'(busB.req_ready_out), 32'd1);
        @(posedge clk); #1;
        busB.be_in = 4'b0011;
        @(negedge clk);
        checkOutput("w0.ld1.respValid", 32'(busB.resp_valid_out), 32'd1);
        checkOutput("w0.ld1.data", busB.data_out, 32'h5A5A0001);
        @(negedge clk);
        checkOutput("w0.gap2.reqReady", 32'(busB.req_ready_out), 32'd1);
        @(negedge clk);
        checkOutput("w0.ld2.respValid", 32'(busB.resp_valid_out), 32'd1);
        checkOutput("w0.ld2.data", busB.data_out, 32'h00000001);
        @(posedge clk); #1;
        busB.req_valid_in = 1'b0; busB.resp_ready_in = 1'b0;
        @(negedge clk);

        // Basic store/load and partial-lane update
        doStore("st0", 12'h000, 4'b1111, 32'hABCDEF00, 1'b0);
        doLoad("ld0", 12'h000, 4'b1111, 32'hABCDEF00, 1'b0);
        doStore("st10", 12'h010, 4'b1111, 32'h00001234, 1'b0);
        doStore("st12", 12'h012, 4'b1100, 32'hFFFF0000, 1'b0);
        doLoad("ld10", 12'h010, 4'b1111, 32'hFFFF1234, 1'b0);
        doLoad("ld10lo", 12'h010, 4'b0011, 32'h00001234, 1'b0);
        doLoad("ld10b2", 12'h013, 4'b0100, 32'h00FF0000, 1'b0);

        // Empty byte enable is a no-op
        doStore("stNone", 12'h000, 4'b0000, 32'h11111111, 1'b0);
        doLoad("ldAfterNone", 12'h000, 4'b1111, 32'hABCDEF00, 1'b0);
        doLoad("ldNone", 12'h000, 4'b0000, 32'h00000000, 1'b0);

        // Non-contiguous byte enable
        doStore("st8", 12'h008, 4'b1111, 32'h01020304, 1'b0);
        doStore("st8odd", 12'h008, 4'b0101, 32'hAABBCCDD, ALIGN_CHECK);
        doLoad("ld8", 12'h008, 4'b1111, ALIGN_CHECK ? 32'h01020304 : 32'h01BB03DD, 1'b0);

        // Top of address space, no wrap onto word 0
        doStore("stTop", 12'hFFC, 4'b1111, 32'hDEADBEEF, 1'b0);
        doLoad("ldTop", 12'hFFF, 4'b1111, 32'hDEADBEEF, 1'b0);
        doLoad("ldBottom", 12'h000, 4'b1111, 32'hABCDEF00, 1'b0);

        // Response backpressure with the next request already waiting
        doStore("st20", 12'h020, 4'b1111, 32'hCAFEF00D, 1'b0);
        busA.req_valid_in = 1'b1; busA.WE_in = 1'b0; busA.addr_in = 12'h020;
        busA.be_in = 4'b1111; busA.data_in = 32'h0;
        @(posedge clk); #1;
        busA.addr_in = 12'h000;
        @(negedge clk);
        checkOutput("bp.wait.reqReady", 32'(busA.req_ready_out), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput($sformatf("bp.hold%0d.respValid", i), 32'(busA.resp_valid_out), 32'd1);
            checkOutput($sformatf("bp.hold%0d.data", i), busA.data_out, 32'hCAFEF00D);
            checkOutput($sformatf("bp.hold%0d.reqReady", i), 32'(busA.req_ready_out), 32'd0);
        end
        busA.resp_ready_in = 1'b1;
        @(posedge clk); #1;
        busA.resp_ready_in = 1'b0;
        @(negedge clk);
        checkOutput("bp.after.respValid", 32'(busA.resp_valid_out), 32'd0);
        checkOutput("bp.after.reqReady", 32'(busA.req_ready_out), 32'd1);
        @(posedge clk); #1;
        busA.req_valid_in = 1'b0;
        @(negedge clk);
        checkOutput("bp.next.reqReady", 32'(busA.req_ready_out), 32'd0);
        @(negedge clk);
        checkOutput("bp.next.respValid", 32'(busA.resp_valid_out), 32'd1);
        checkOutput("bp.next.data", busA.data_out, 32'hABCDEF00);
        busA.resp_ready_in = 1'b1;
        @(posedge clk); #1;
        busA.resp_ready_in = 1'b0;
        @(negedge clk);

        // Reset while a store sits in WAIT
        doStore("st4", 12'h004, 4'b1111, 32'h00000077, 1'b0);
        busA.req_valid_in = 1'b1; busA.WE_in = 1'b1; busA.addr_in = 12'h004;
        busA.be_in = 4'b1111; busA.data_in = 32'h00000010;
        @(posedge clk); #1;
        busA.req_valid_in = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        checkOutput("abort.wait.respValid", 32'(busA.resp_valid_out), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput($sformatf("abort.idle%0d.respValid", i), 32'(busA.resp_valid_out), 32'd0);
        end
        checkOutput("abort.reqReady", 32'(busA.req_ready_out), 32'd1);
        doLoad("ld4", 12'h004, 4'b1111, 32'h00000077, 1'b0);
        doLoad("ldKept", 12'h000, 4'b1111, 32'hABCDEF00, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter ADDRESS_SPACE, default 4096, meaning memory size in bytes (power of two, multiple of 4).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, meaning word width; only 32 is supported.
REQ-003 The block SHALL have parameter WAIT_CYCLES, default 1, meaning wait states between request accept and response (range 0-15).
REQ-004 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1, a synchronous active-low reset.
REQ-006 The block SHALL have port req_valid_in, input, 1, meaning the initiator (LSU) presents a request.
REQ-007 The block SHALL have port req_ready_out, output, 1, meaning the responder accepts a request this cycle.
REQ-008 The block SHALL have port addr_in, input, $clog2(ADDRESS_SPACE), a byte address; bits [1:0] are ignored for word select.
REQ-009 The block SHALL have port WE_in, input, 1, where 1 = store and 0 = load.
REQ-010 The block SHALL have port be_in, input, 4, byte enables within the addressed word.
REQ-011 The block SHALL have port data_in, input, DATA_WIDTH, the store data, already lane-aligned.
REQ-012 The block SHALL have port resp_valid_out, output, 1, meaning a response is present.
REQ-013 The block SHALL have port resp_ready_in, input, 1, meaning the initiator consumes the response.
REQ-014 The block SHALL have port data_out, output, DATA_WIDTH, the load data with non-enabled lanes zero.
REQ-015 The block SHALL have port err_out, output, 1, an error flag that is valid with resp_valid_out.

Function
REQ-016 The FSM SHALL have the states IDLE, WAIT and RESP.
REQ-017 req_ready_out SHALL be 1 only in IDLE; a request is accepted on a cycle with req_valid_in && req_ready_out, and addr_in, WE_in, be_in and data_in are registered.
REQ-018 On accept, the FSM SHALL go to WAIT with the wait counter loaded to WAIT_CYCLES-1; if WAIT_CYCLES=0 it SHALL go directly to RESP.
REQ-019 In WAIT, the counter SHALL decrement each cycle, and the FSM SHALL go to RESP on the edge where the counter is 0.
REQ-020 Total latency SHALL be: resp_valid_out asserts WAIT_CYCLES+1 cycles after the accept edge.
REQ-021 A store SHALL update only the enabled byte lanes on the edge entering RESP; a store response SHALL drive data_out=0.
REQ-022 A load SHALL sample the word on the edge entering RESP; data_out = word masked by be_in.
REQ-023 In RESP, resp_valid_out=1 and data_out/err_out SHALL be held stable until resp_ready_in=1; on that edge the FSM SHALL return to IDLE.
REQ-024 A new request SHALL NOT be accepted in the same cycle as the response handshake; the earliest next accept is the cycle after.
REQ-025 A load to the address of the immediately preceding store SHALL return the stored data (read-after-write).
REQ-026 The word index SHALL be addr_in[$clog2(ADDRESS_SPACE)-1:2], with no wrap-around beyond ADDRESS_SPACE.
REQ-027 be_in=0000 SHALL be a legal no-op: no memory change, data_out=0.

Reset
REQ-028 When reset_n=0 at a clock edge, the FSM SHALL go to IDLE, req_ready_out SHALL be 1 after reset release, and resp_valid_out, data_out and err_out SHALL be 0.
REQ-029 Reset mid-operation SHALL abort the transaction: a store still in WAIT is not committed, and a pending response is dropped.
REQ-030 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-031 The macro DMEM_ALIGN_CHECK_EN SHALL control byte-enable legality checking.
REQ-032 With DMEM_ALIGN_CHECK_EN defined, legal be_in SHALL be 0000, 0001, 0010, 0100, 1000, 0011, 1100 and 1111; any other value yields err_out=1 in RESP, no memory write and data_out=0.
REQ-033 Without DMEM_ALIGN_CHECK_EN, err_out SHALL be tied to 0 and every be_in pattern SHALL be applied lane-wise.

Structure
REQ-034 Package dmem_pkg SHALL hold the FSM state enum, the WORD_BYTES=4 constant and the legal byte-enable pattern constants.
REQ-035 Sub-module dmem_byte_ram SHALL implement the word RAM with a synchronous write and per-lane byte enables; dmem_responder holds the FSM, counter and checks.

Verification
REQ-036 After reset, store addr 0x000, be=1111, data 0xABCDEF00 -> resp_valid_out 2 cycles after accept (WAIT_CYCLES=1), err_out=0; then load 0x000, be=1111 -> data_out=0xABCDEF00.
REQ-037 Store 0x012, be=1100, data 0xFFFF0000 over existing word 0x00001234 -> load be=1111 returns 0xFFFF1234.
REQ-038 Response backpressure: load with resp_ready_in=0 for 5 cycles -> resp_valid_out and data_out stable and req_ready_out=0 throughout; accept occurs only the cycle after resp_ready_in=1.
REQ-039 Reset asserted while a store to 0x004 (data 0x00000010) is in WAIT -> after reset, load 0x004 returns the prior contents and no response is issued for the aborted store.
REQ-040 With DMEM_ALIGN_CHECK_EN, store be=0101 to 0x008 -> err_out=1, memory unchanged; without the macro -> err_out=0 and lanes 0 and 2 are written.
REQ-041 With WAIT_CYCLES=0, back-to-back loads -> each resp_valid_out 1 cycle after accept, with one idle cycle between accepts.
